sdram_arbiter: RTL and testbench
================================

# sdram_arbiter

Round-robin arbiter that shares the single SDRAM controller port among several toggle-handshake requesters, such as CHR RAM, PRG RAM and the MCU loader. It sits between the requester-side bus logic and the SDRAM controller. Each requester sees a private, independent req/ack channel. Exactly one transaction is forwarded to the controller at a time, and read data is held per port.

## Interface
- NUM_PORTS, 3, number of requesters (2..8)
- ADDR_BITS, 22, SDRAM word-address width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- p_req  in  NUM_PORTS  per-port request toggle
- p_ack  out  NUM_PORTS  per-port acknowledge toggle
- p_we  in  NUM_PORTS  per-port write enable (1 = write)
- p_address  in  NUM_PORTS x ADDR_BITS  per-port word address
- p_data_write  in  NUM_PORTS x 16  per-port write data
- p_wm  in  NUM_PORTS x 2  per-port write mask; bit set = byte masked
- p_data_read  out  NUM_PORTS x 16  per-port read data, held until that port's next read completes
- m_req  out  1  controller request toggle
- m_ack  in  1  controller acknowledge toggle
- m_we  out  1  latched write enable
- m_address  out  ADDR_BITS  latched address
- m_data_write  out  16  latched write data
- m_wm  out  2  latched write mask
- m_data_read  in  16  controller read data, valid when m_ack == m_req
- busy  out  1  transaction in flight
- grant  out  3  index of the port currently or last served

## Operation
- Port i is pending when p_req[i] != p_ack[i].
- Requester rules:
  - p_we, p_address, p_data_write and p_wm stay stable while the port is pending.
  - The port must not toggle p_req again before p_ack matches; a double toggle is unsupported.
- FSM has two states.
- IDLE:
  - Scan ports starting at (last + 1) mod NUM_PORTS.
  - The first pending port wins. Latch its fields into the m_* outputs, toggle m_req, set grant and last to the winner, set busy=1, go to BUSY.
  - If nothing is pending, stay in IDLE.
- BUSY:
  - While m_ack != m_req, hold every m_* output and perform no scanning.
  - When m_ack == m_req:
    - If m_we == 0, latch m_data_read into p_data_read[grant].
    - Toggle p_ack[grant], set busy=0, go to IDLE.
- Writes leave p_data_read[grant] unchanged.
- Ports not granted see no change on p_ack or p_data_read.
- Fairness: a continuously pending port is served within NUM_PORTS grants.
- Requests arriving during BUSY are not lost; they are evaluated in the next IDLE cycle.
- A port toggling p_req in the same cycle its p_ack toggles is not pending until the following cycle. Its new request is seen then.

## Timing
- Reset values:
  - state=IDLE, m_req=0, m_we=0, m_address=0, m_data_write=0, m_wm=0.
  - p_ack=0, p_data_read=0, busy=0, grant=0, last=NUM_PORTS-1 (port 0 scanned first).
- Reset mid-transaction drops the in-flight request with no p_ack toggle. The controller and requesters share the same reset and also return to req=ack=0.
- Port i pending at edge k (IDLE): the m_* fields and toggled m_req are visible after edge k.
- m_ack matching is sampled at edge m: the p_ack toggle and p_data_read are visible after edge m.
- Arbiter overhead is 2 cycles per transaction, plus the controller latency.
- At least one IDLE cycle separates transactions; the next grant is at edge m+1 at the earliest.
- Arithmetic: the pointer wraps modulo NUM_PORTS; grant is zero-extended to 3 bits.

## Test plan
- Single read:
  - Stimulus: port 0 reads address 0x1234; controller model returns 0xBEEF after 5 cycles.
  - Required: m_req toggles 1 cycle after the request; m_address=0x1234, m_we=0; p_ack[0] toggles 1 cycle after m_ack; p_data_read[0]=0xBEEF; p_data_read[1..2] stay 0.
- Simultaneous requests:
  - Stimulus: ports 0, 1 and 2 toggle p_req in the same cycle after reset.
  - Required: grant order 0, 1, 2; each p_ack toggles exactly once; one idle cycle between m_req toggles.
- Fairness:
  - Stimulus: port 1 re-requests immediately after every ack; port 2 requests once.
  - Required: port 2 is granted right after port 1's first grant, i.e. second overall.
- Write passthrough:
  - Stimulus: port 2 writes 0xA5A5, wm=2'b10, address 0x3FFFFF.
  - Required: the m_* outputs match exactly; p_data_read[2] is unchanged; p_ack[2] toggles.
- Reset mid-transaction:
  - Stimulus: assert reset while busy=1 and m_ack is still outstanding.
  - Required: the next cycle shows m_req=0, all p_ack=0, busy=0, and no stale ack afterwards. A new port 1 request is then served normally.
- Stability:
  - Stimulus: the controller holds m_ack unmatched for 100 cycles while other ports toggle requests.
  - Required: the m_* outputs stay constant, grant is unchanged, and no p_ack toggles until completion.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter that shares one toggle-handshake SDRAM
// controller port among NUM_PORTS toggle-handshake requesters. Only one
// transaction is in flight at a time. Read data is held per port until that
// port's next read completes.
module sdram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_BITS = 22
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 p_req,
    output logic [NUM_PORTS-1:0]                 p_ack,
    input  logic [NUM_PORTS-1:0]                 p_we,
    input  logic [NUM_PORTS-1:0][ADDR_BITS-1:0]  p_address,
    input  logic [NUM_PORTS-1:0][15:0]           p_data_write,
    input  logic [NUM_PORTS-1:0][1:0]            p_wm,
    output logic [NUM_PORTS-1:0][15:0]           p_data_read,
    output logic                                 m_req,
    input  logic                                 m_ack,
    output logic                                 m_we,
    output logic [ADDR_BITS-1:0]                 m_address,
    output logic [15:0]                          m_data_write,
    output logic [1:0]                           m_wm,
    input  logic [15:0]                          m_data_read,
    output logic                                 busy,
    output logic [2:0]                           grant
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t               state;
    logic [IDX_W-1:0]     last;
    logic [IDX_W-1:0]     grant_idx;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     cand;
    logic                 found;
    logic [NUM_PORTS-1:0] pending;
    int                   scan_idx;

    // A port has an outstanding request whenever its two toggles disagree.
    assign pending = p_req ^ p_ack;
    assign grant   = 3'(grant_idx);

    // Rotating priority search: start just after the last winner and take the
    // first pending port, so a continuously pending port waits at most one lap.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        cand     = '0;
        scan_idx = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            scan_idx = (int'(last) + k) % NUM_PORTS;
            cand     = IDX_W'(scan_idx);
            if (!found && pending[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Two-state transaction FSM: IDLE picks a winner and launches it, BUSY
    // holds the controller port stable until the controller toggles back.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            m_req        <= 1'b0;
            m_we         <= 1'b0;
            m_address    <= '0;
            m_data_write <= '0;
            m_wm         <= '0;
            p_ack        <= '0;
            p_data_read  <= '0;
            busy         <= 1'b0;
            grant_idx    <= '0;
            last         <= IDX_W'(NUM_PORTS - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        m_we         <= p_we[winner];
                        m_address    <= p_address[winner];
                        m_data_write <= p_data_write[winner];
                        m_wm         <= p_wm[winner];
                        m_req        <= ~m_req;
                        grant_idx    <= winner;
                        last         <= winner;
                        busy         <= 1'b1;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (m_ack == m_req) begin
                        // Writes leave the port's read-data register untouched.
                        if (!m_we) begin
                            p_data_read[grant_idx] <= m_data_read;
                        end
                        p_ack[grant_idx] <= ~p_ack[grant_idx];
                        busy             <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: randomized and directed stimulus for sdram_arbiter with a
// transaction-level reference model and a controller/requester model.
module tb_sdram_arbiter;

    localparam int N  = 3;
    localparam int AW = 22;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [N-1:0]          p_req;
    logic [N-1:0]          p_ack;
    logic [N-1:0]          p_we;
    logic [N-1:0][AW-1:0]  p_address;
    logic [N-1:0][15:0]    p_data_write;
    logic [N-1:0][1:0]     p_wm;
    logic [N-1:0][15:0]    p_data_read;
    logic                  m_req;
    logic                  m_ack;
    logic                  m_we;
    logic [AW-1:0]         m_address;
    logic [15:0]           m_data_write;
    logic [1:0]            m_wm;
    logic [15:0]           m_data_read;
    logic                  busy;
    logic [2:0]            grant;

    sdram_arbiter #(.NUM_PORTS(N), .ADDR_BITS(AW)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_ack(p_ack), .p_we(p_we), .p_address(p_address),
        .p_data_write(p_data_write), .p_wm(p_wm), .p_data_read(p_data_read),
        .m_req(m_req), .m_ack(m_ack), .m_we(m_we), .m_address(m_address),
        .m_data_write(m_data_write), .m_wm(m_wm), .m_data_read(m_data_read),
        .busy(busy), .grant(grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model state
    bit                 model_valid = 1'b0;
    bit                 md_busy;
    int                 md_grant;
    int                 md_last;
    logic               md_mreq;
    logic               md_we;
    logic [AW-1:0]      md_addr;
    logic [15:0]        md_dw;
    logic [1:0]         md_wm;
    logic [N-1:0]       md_ack;
    logic [N-1:0][15:0] md_dr;

    // controller / requester models
    bit           ctrl_rand = 1'b0;
    int           ctrl_lat = 1;
    int           cur_lat = 1;
    int           ctrl_cnt = 0;
    logic [15:0]  ctrl_val = 16'h0;
    logic [N-1:0] rand_en = '0;
    logic [N-1:0] rereq = '0;
    logic         prev_mreq = 1'b0;
    int           grant_log[$];
    int           tog_cyc[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // round robin: first pending port after the previous winner
    function automatic int pick(input logic [N-1:0] pend, input int prev);
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (prev + off) % N;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (reset) begin
            model_valid = 1'b1;
            md_busy = 1'b0; md_grant = 0; md_last = N - 1;
            md_mreq = 1'b0; md_we = 1'b0; md_addr = '0; md_dw = '0; md_wm = '0;
            md_ack = '0; md_dr = '0;
        end else if (model_valid) begin
            if (!md_busy) begin
                w = pick(p_req ^ md_ack, md_last);
                if (w >= 0) begin
                    md_mreq = ~md_mreq;
                    md_we = p_we[w]; md_addr = p_address[w];
                    md_dw = p_data_write[w]; md_wm = p_wm[w];
                    md_grant = w; md_last = w; md_busy = 1'b1;
                end
            end else if (m_ack == md_mreq) begin
                if (!md_we) md_dr[md_grant] = m_data_read;
                md_ack[md_grant] = ~md_ack[md_grant];
                md_busy = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("m_req", m_req, md_mreq);
        check("m_we", m_we, md_we);
        check("m_address", m_address, md_addr);
        check("m_data_write", m_data_write, md_dw);
        check("m_wm", m_wm, md_wm);
        check("busy", busy, md_busy);
        check("grant", grant, 3'(md_grant));
        check("p_ack", p_ack, md_ack);
        check("p_data_read", p_data_read, md_dr);
    endtask

    task automatic issue(input int i);
        p_we[i] = 1'($urandom);
        p_address[i] = AW'($urandom);
        p_data_write[i] = 16'($urandom);
        p_wm[i] = 2'($urandom);
        p_req[i] = ~p_req[i];
    endtask

    task automatic controller_step();
        if (reset) begin
            m_ack = 1'b0;
            ctrl_cnt = 0;
        end else if (m_req != m_ack) begin
            if (ctrl_cnt == 0) cur_lat = ctrl_rand ? int'($urandom_range(1, 6)) : ctrl_lat;
            ctrl_cnt++;
            if (ctrl_cnt >= cur_lat) begin
                m_data_read = ctrl_rand ? 16'($urandom) : ctrl_val;
                m_ack = m_req;
                ctrl_cnt = 0;
            end
        end
    endtask

    task automatic requester_step();
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (p_req[i] == p_ack[i]) begin
                    if (rereq[i]) issue(i);
                    else if (rand_en[i] && $urandom_range(0, 3) == 0) issue(i);
                end
            end
        end
    endtask

    // one clock: model on the rising edge, compare and drive on the falling edge
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        if (model_valid) compare_all();
        if (m_req != prev_mreq) begin
            grant_log.push_back(int'(grant));
            tog_cyc.push_back(cyc);
        end
        prev_mreq = m_req;
        controller_step();
        requester_step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        p_req = '0; p_we = '0; p_address = '0; p_data_write = '0; p_wm = '0;
        rand_en = '0; rereq = '0; ctrl_rand = 1'b0;
        m_ack = 1'b0; ctrl_cnt = 0;
        tick();
        tick();
        reset = 1'b0;
        grant_log.delete();
        tog_cyc.delete();
    endtask

    task automatic wait_ack(input int i, input logic target, input string name);
        int n;
        n = 0;
        while (p_ack[i] != target && n < 300) begin
            tick();
            n++;
        end
        check(name, p_ack[i], target);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (p_req != p_ack && n < 300) begin
            tick();
            n++;
        end
        check(name, p_ack, p_req);
    endtask

    initial begin
        bit ok;
        logic [N-1:0] pa_snap;
        reset = 1'b1;
        p_req = '0; p_we = '0; p_address = '0; p_data_write = '0; p_wm = '0;
        m_ack = 1'b0; m_data_read = '0;

        // reset state
        do_reset();
        check("rst_m_req", m_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 3'd0);
        check("rst_p_ack", p_ack, 3'b000);
        check("rst_p_data_read", p_data_read, 48'h0);
        check("rst_m_address", m_address, 22'h0);

        // single read from port 0
        ctrl_lat = 5; ctrl_val = 16'hBEEF;
        p_we[0] = 1'b0; p_address[0] = 22'h1234; p_req[0] = 1'b1;
        tick();
        check("rd_m_req", m_req, 1'b1);
        check("rd_m_address", m_address, 22'h1234);
        check("rd_m_we", m_we, 1'b0);
        check("rd_grant", grant, 3'd0);
        wait_ack(0, 1'b1, "rd_ack_wait");
        check("rd_ack_latency", cyc - tog_cyc[0], 5);
        check("rd_data0", p_data_read[0], 16'hBEEF);
        check("rd_data1", p_data_read[1], 16'h0000);
        check("rd_data2", p_data_read[2], 16'h0000);

        // simultaneous requests from all ports
        do_reset();
        ctrl_lat = 1; ctrl_val = 16'h0001;
        p_req = 3'b111;
        begin
            int n;
            n = 0;
            while (p_ack != 3'b111 && n < 60) begin
                tick();
                n++;
            end
        end
        check("sim_p_ack", p_ack, 3'b111);
        check("sim_count", grant_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < grant_log.size()) check("sim_order", grant_log[i], i);
        end
        for (int i = 1; i < 3; i++) begin
            if (i < tog_cyc.size()) check("sim_gap", tog_cyc[i] - tog_cyc[i-1], 2);
        end

        // fairness: port 1 hammers, port 2 asks once
        do_reset();
        ctrl_lat = 2;
        rereq[1] = 1'b1;
        p_req[1] = 1'b1; p_req[2] = 1'b1;
        begin
            int n;
            n = 0;
            while (grant_log.size() < 4 && n < 100) begin
                tick();
                n++;
            end
        end
        check("fair_count", grant_log.size() >= 4, 1'b1);
        if (grant_log.size() >= 3) begin
            check("fair_first", grant_log[0], 1);
            check("fair_second", grant_log[1], 2);
            check("fair_third", grant_log[2], 1);
        end
        rereq = '0;
        drain("fair_drain");

        // write passthrough on port 2, preceded by a read to seed its data
        do_reset();
        ctrl_lat = 3; ctrl_val = 16'h1357;
        p_we[2] = 1'b0; p_address[2] = 22'h10; p_req[2] = 1'b1;
        wait_ack(2, 1'b1, "wr_seed_ack");
        check("wr_seed_data", p_data_read[2], 16'h1357);
        ctrl_val = 16'h0BAD;
        p_we[2] = 1'b1; p_data_write[2] = 16'hA5A5; p_wm[2] = 2'b10;
        p_address[2] = 22'h3FFFFF; p_req[2] = 1'b0;
        tick();
        check("wr_m_we", m_we, 1'b1);
        check("wr_m_address", m_address, 22'h3FFFFF);
        check("wr_m_data_write", m_data_write, 16'hA5A5);
        check("wr_m_wm", m_wm, 2'b10);
        check("wr_grant", grant, 3'd2);
        wait_ack(2, 1'b0, "wr_ack");
        check("wr_data_kept", p_data_read[2], 16'h1357);

        // reset while a transaction is outstanding
        do_reset();
        ctrl_lat = 100;
        p_we[0] = 1'b0; p_address[0] = 22'h55; p_req[0] = 1'b1;
        tick();
        tick();
        check("rm_busy", busy, 1'b1);
        check("rm_outstanding", m_req != m_ack, 1'b1);
        reset = 1'b1; p_req = '0;
        tick();
        reset = 1'b0;
        check("rm_m_req", m_req, 1'b0);
        check("rm_p_ack", p_ack, 3'b000);
        check("rm_busy_clr", busy, 1'b0);
        ctrl_lat = 3; ctrl_val = 16'h4242;
        repeat (5) tick();
        check("rm_no_stale", p_ack, 3'b000);
        p_we[1] = 1'b0; p_address[1] = 22'h77; p_req[1] = 1'b1;
        tick();
        check("rm_grant", grant, 3'd1);
        wait_ack(1, 1'b1, "rm_new_ack");
        check("rm_new_data", p_data_read[1], 16'h4242);

        // stability while the controller stalls
        do_reset();
        ctrl_lat = 100;
        p_we[0] = 1'b1; p_address[0] = 22'h0ABCDE; p_data_write[0] = 16'h1111;
        p_wm[0] = 2'b01; p_req[0] = 1'b1;
        tick();
        rand_en = 3'b110;
        ok = 1'b1;
        pa_snap = p_ack;
        repeat (95) begin
            tick();
            if (m_address != 22'h0ABCDE || m_we != 1'b1 || m_data_write != 16'h1111 ||
                m_wm != 2'b01 || grant != 3'd0 || busy != 1'b1 || p_ack != 3'b000)
                ok = 1'b0;
        end
        check("stable_hold", ok, 1'b1);
        check("stable_p_ack", pa_snap, 3'b000);
        rand_en = '0;
        wait_ack(0, 1'b1, "stable_ack");
        ctrl_lat = 2;
        drain("stable_drain");

        // randomized traffic with one reset in the middle
        do_reset();
        ctrl_rand = 1'b1;
        rand_en = '1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset = 1'b1; p_req = '0;
                tick();
                reset = 1'b0;
            end else begin
                tick();
            end
        end
        rand_en = '0;
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
